prio_enco: RTL and testbench
============================

// Module: prio_enco
// PURPOSE
//  - Sequential 8:3 priority encoder: the encode-side counterpart of the 3:8 decoder (deco).
//  - Captures a one-hot or multi-hot request vector through a valid/ready handshake.
//  - Emits the index of every set bit as a 3-bit code, one code per handshake, highest index first.
//  - Feeds deco downstream and turns request/interrupt lines into binary indices.
// PARAMETERS
//  - N  8  request vector width; power of two, >= 2.
//  - W  3  code width; fixed to $clog2(N). Derived only, never overridden.
// PORTS
//  - clk         in   1  rising-edge clock; the block's single clock.
//  - rst         in   1  asynchronous, active-high reset.
//  - en          in   1  block enable; 0 freezes all state.
//  - req_valid   in   1  req is valid.
//  - req_ready   out  1  block can accept req this cycle.
//  - req         in   N  request vector; bit i set means index i is requested.
//  - code_valid  out  1  code, last and mask are valid.
//  - code_ready  in   1  sink accepts code this cycle.
//  - code        out  W  index of the highest set bit still pending.
//  - last        out  1  code is the final pending index of the captured vector.
//  - none        out  1  one-cycle pulse: an all-zero vector was accepted.
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - state=IDLE, pending=0.
//    - code_valid=0, code=0, last=0, none=0.
//    - req_ready=0 while rst=1.
//  - State IDLE:
//    - req_ready = en. code_valid=0.
//    - Accept (req_valid & req_ready) with req!=0: pending<=req, go to SCAN.
//    - Accept with req==0: none=1 for the next cycle, stay in IDLE.
//  - State SCAN:
//    - code_valid = en.
//    - code = highest i with pending[i]=1.
//    - last = (pending has exactly one bit set).
//    - Sink handshake (code_valid & code_ready) clears pending[code].
//    - If last, the handshake also returns the block to IDLE.
//  - Back-to-back:
//    - In SCAN, req_ready = en & last & code_ready. This is combinational from code_ready.
//    - A new vector can therefore load in the cycle of the final code handshake.
//    - If that new vector is nonzero, state stays in SCAN with no idle bubble.
//    - If it is zero, state goes to IDLE and none pulses.
//  - Latency and throughput:
//    - A vector accepted at edge k gives code_valid=1 from the cycle after k.
//    - One code per cycle while code_ready=1.
//    - A vector with p set bits takes exactly p handshakes.
//  - Backpressure: while code_ready=0, code, last and pending hold stable and code_valid stays 1.
//  - en=0:
//    - req_ready=0 and code_valid=0.
//    - State, pending and code registers hold; none is forced 0.
//    - Resuming en=1 continues exactly where the block stopped.
//  - Outputs code and last are decoded from the pending register, so they carry no
//    combinational path from req.
//  - Reset mid-SCAN: all pending codes are discarded. No code is emitted after rst deasserts
//    until a new accept.
// STRUCTURE
//  - Package prio_enco_pkg holds:
//    - localparams N and W;
//    - state typedef enum {IDLE, SCAN};
//    - function onehot(idx) returning an N-bit mask.
//  - Sub-module prio_find (combinational, parameter N), instantiated once on pending.
//    - Inputs: vec[N-1:0].
//    - Outputs: idx[W-1:0] (highest set bit), any, single (exactly one set bit).
//  - Top level holds: state register, pending register, none register, handshake logic.
// TESTING
//  - Single bit: after reset, req=8'b0010_0000 accepted, code_ready=1.
//    -> one code=5 with last=1, then IDLE and req_ready=1.
//  - Multi-bit order: req=8'b1000_0101, code_ready=1.
//    -> codes 7, 2, 0 on consecutive cycles; last=1 only on code 0.
//  - Backpressure: req=8'b0001_1000, code_ready=0 for 4 cycles.
//    -> code=4, last=0 held with code_valid=1; after release, codes 4 then 3.
//  - Zero vector: req=8'h00 accepted.
//    -> none=1 for exactly one cycle, code_valid stays 0, state stays IDLE.
//  - Back-to-back: req=8'h01, then req=8'h80 presented in the final-handshake cycle.
//    -> code 0 (last), then code 7 the next cycle, no bubble.
//  - en and reset:
//    - en=0 mid-SCAN on 8'b0110_0000 after code 6 -> outputs frozen; en=1 -> code 5 resumes.
//    - rst pulse mid-SCAN -> code_valid=0 immediately and pending=0.

Source files
------------

// File: rtl/prio_enco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prio_enco_pkg
// Description : Shared constants, state type and mask helper for the
//               sequential 8:3 priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package prio_enco_pkg;

    // Request vector width (power of two, >= 2) and the derived code width.
    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // N-bit mask with only bit idx set.
    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage : prio_enco_pkg
`default_nettype wire

// File: rtl/prio_find.sv
`default_nettype none
// ============================================================================
// Module      : prio_find
// Description : Combinational highest-set-bit finder.
//   vec    : input vector
//   idx    : index of the highest set bit (0 when vec is all zero)
//   any    : at least one bit set
//   single : exactly one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_find #(
    parameter int N = 8
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any,
    output logic                 single
);

    localparam int W = $clog2(N);

    // Ascending scan: the last hit wins, so idx ends on the highest set bit.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign single = any && ((vec & (vec - 1'b1)) == '0);

endmodule : prio_find
`default_nettype wire

// File: rtl/prio_enco.sv
`default_nettype none
// ============================================================================
// Module      : prio_enco
// Description : Sequential 8:3 priority encoder. Captures a request vector
//               over a valid/ready handshake and emits the index of every set
//               bit, highest first, one code per downstream handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   en                  : block enable; 0 freezes all state
//   req_valid/req_ready : request handshake, req is the N-bit vector
//   code_valid/ready    : code handshake; code/last valid with code_valid
//   code                : highest pending index
//   last                : code is the final pending index
//   none                : one-cycle pulse after an all-zero vector is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enco
    import prio_enco_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code,
    output logic         last,
    output logic         none
);

    state_t         r_state_q;
    state_t         w_state_d;
    logic [N-1:0]   r_pending_q;
    logic [N-1:0]   w_pending_d;
    logic           r_none_q;
    logic           w_none_d;

    logic [W-1:0]   w_idx;
    logic           w_any;
    logic           w_single;
    logic           w_accept;
    logic           w_code_hs;
    logic           w_req_zero;

    // code and last come only from the pending register, never from req.
    prio_find #(
        .N (N)
    ) u_find (
        .vec    (r_pending_q),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_single)
    );

    assign code = w_idx;
    assign last = w_single;

    // In SCAN a new vector may load only alongside the final code handshake,
    // which gives back-to-back vectors without an idle bubble.
    always_comb begin
        req_ready = 1'b0;
        if (en && !rst) begin
            if (r_state_q == IDLE) begin
                req_ready = 1'b1;
            end else begin
                req_ready = w_single & code_ready;
            end
        end
    end

    assign code_valid = en & (r_state_q == SCAN) & w_any;
    assign none       = r_none_q & en;

    assign w_accept   = req_valid & req_ready;
    assign w_code_hs  = code_valid & code_ready;
    assign w_req_zero = (req == '0);

    always_comb begin
        w_state_d   = r_state_q;
        w_pending_d = r_pending_q;
        w_none_d    = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_zero) begin
                        w_none_d = 1'b1;
                    end else begin
                        w_pending_d = req;
                        w_state_d   = SCAN;
                    end
                end
            end
            SCAN: begin
                if (w_code_hs) begin
                    w_pending_d = r_pending_q & ~onehot(w_idx);
                    if (w_single) begin
                        w_state_d = IDLE;
                        if (w_accept) begin
                            if (w_req_zero) begin
                                w_none_d = 1'b1;
                            end else begin
                                w_pending_d = req;
                                w_state_d   = SCAN;
                            end
                        end
                    end
                end
            end
            default: begin
                w_state_d   = IDLE;
                w_pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_pending_q <= '0;
            r_none_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_pending_q <= w_pending_d;
            r_none_q    <= w_none_d;
        end
    end

endmodule : prio_enco
`default_nettype wire

// File: tb/tb_prio_enco.sv
`default_nettype none
// ============================================================================
// Module      : tb_prio_enco
// Description : Self-checking bench for prio_enco. A queue of pending indices
//               (highest first) models the block; every cycle all outputs are
//               compared against it under directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prio_enco;

    localparam int C_N = 8;

    logic           clk;
    logic           rst;
    logic           en;
    logic           req_valid;
    logic           req_ready;
    logic [C_N-1:0] req;
    logic           code_valid;
    logic           code_ready;
    logic [2:0]     code;
    logic           last;
    logic           none;

    int n_cmp;
    int n_err;

    // Reference model state: indices still to be emitted, highest first.
    int q[$];
    bit none_m;

    prio_enco u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req        (req),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .last       (last),
        .none       (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int  e_code;
        bit  e_cv, e_last, e_rr, e_none;
        e_cv   = en && !rst && (q.size() > 0);
        e_code = (q.size() > 0) ? q[0] : 0;
        e_last = (q.size() == 1);
        e_rr   = en && !rst && ((q.size() == 0) || ((q.size() == 1) && code_ready));
        e_none = none_m && en && !rst;
        chk("code_valid", int'(code_valid), int'(e_cv));
        chk("code",       int'(code),       e_code);
        chk("last",       int'(last),       int'(e_last));
        chk("req_ready",  int'(req_ready),  int'(e_rr));
        chk("none",       int'(none),       int'(e_none));
    endtask

    // One clock: check current outputs, advance the model, take the edge.
    task automatic tick();
        bit hs, acc;
        #1;
        check_outputs();
        hs  = en && (q.size() > 0) && code_ready;
        acc = req_valid && en && ((q.size() == 0) || ((q.size() == 1) && code_ready));
        if (hs) void'(q.pop_front());
        none_m = acc && (req == '0);
        if (acc && req != '0) begin
            for (int i = C_N - 1; i >= 0; i--) begin
                if (req[i]) q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        q.delete();
        none_m = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        none_m     = 1'b0;
        rst        = 1'b0;
        en         = 1'b1;
        req_valid  = 1'b0;
        req        = '0;
        code_ready = 1'b1;
        #2;
        apply_reset();
        tick();

        // Single bit: one code 5 with last, then idle.
        req_valid = 1'b1; req = 8'b0010_0000; tick();
        req_valid = 1'b0; req = '0;
        chk("single_cv", int'(code_valid), 1);
        chk("single_code", int'(code), 5);
        chk("single_last", int'(last), 1);
        tick(); tick();

        // Multi-bit order: 7, 2, 0.
        req_valid = 1'b1; req = 8'b1000_0101; tick();
        req_valid = 1'b0; req = '0;
        chk("multi_first", int'(code), 7);
        tick(); chk("multi_second", int'(code), 2);
        tick(); chk("multi_third", int'(code), 0);
        chk("multi_last", int'(last), 1);
        tick(); tick();

        // Backpressure: hold on code 4 for 4 cycles.
        req_valid = 1'b1; req = 8'b0001_1000; tick();
        req_valid = 1'b0; req = '0; code_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_code", int'(code), 4);
        code_ready = 1'b1;
        tick(); chk("bp_next", int'(code), 3);
        tick(); tick();

        // Zero vector: a single none pulse.
        req_valid = 1'b1; req = 8'h00; tick();
        req_valid = 1'b0;
        chk("zero_none", int'(none), 1);
        tick();
        chk("zero_none_gone", int'(none), 0);
        tick();

        // Back-to-back: 8'h01 then 8'h80 in the final-handshake cycle.
        req_valid = 1'b1; req = 8'h01; tick();
        req = 8'h80; tick();
        req_valid = 1'b0; req = '0;
        chk("b2b_code", int'(code), 7);
        chk("b2b_cv", int'(code_valid), 1);
        tick(); tick();

        // Enable freeze mid-scan on 8'b0110_0000 after code 6.
        req_valid = 1'b1; req = 8'b0110_0000; tick();
        req_valid = 1'b0; req = '0;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        en = 1'b1;
        chk("en_resume", int'(code), 5);
        tick(); tick();

        // Reset mid-scan discards pending codes.
        req_valid = 1'b1; req = 8'b1111_0000; tick();
        req_valid = 1'b0; req = '0;
        tick();
        #2;
        apply_reset();
        chk("rst_cv", int'(code_valid), 0);
        for (int i = 0; i < 3; i++) tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            en         = ($urandom_range(0, 9) != 0);
            req_valid  = ($urandom_range(0, 2) != 0);
            code_ready = ($urandom_range(0, 3) != 0);
            req        = ($urandom_range(0, 7) == 0) ? 8'h00 : C_N'($urandom);
            tick();
        end
        en = 1'b1; req_valid = 1'b0; code_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_prio_enco
`default_nettype wire
